pipe_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage core. It tracks the destination registers of the instructions in EX and MEM, and drives the ID-stage operand forwarding selects (`ra_fwd_ctrl`, `rb_fwd_ctrl`). It sequences load-use stalls, memory-busy freezes and IF flushes on taken jumps. It sits beside `id_stage` and consumes the decoder's operand and destination information.

---
 rtl/pipe_ctrl_pkg.sv | 42 ++++
 rtl/pipe_ctrl_fwd_sel.sv | 19 +
 rtl/pipe_ctrl.sv | 121 ++++++++++++
 tb/tb_pipe_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared encodings and slot types for the pipeline hazard controller.
package pipe_ctrl_pkg;
    localparam int REG_ADDR_W   = 5;
    localparam int MEM_OP_W     = 3;
    localparam int FWD_CTRL_BUS = 2;
    localparam int SRC_USE_RA   = 0;
    localparam int SRC_USE_RB   = 1;
    localparam logic [FWD_CTRL_BUS-1:0] FWD_CTRL_NONE = 2'd0;
    localparam logic [FWD_CTRL_BUS-1:0] FWD_CTRL_EX   = 2'd1;
    localparam logic [FWD_CTRL_BUS-1:0] FWD_CTRL_MEM  = 2'd2;
    localparam logic [MEM_OP_W-1:0] MEM_OP_NOP = 3'd0;
    localparam logic [MEM_OP_W-1:0] MEM_OP_LDB = 3'd1;
    localparam logic [MEM_OP_W-1:0] MEM_OP_LDH = 3'd2;
    localparam logic [MEM_OP_W-1:0] MEM_OP_LDW = 3'd3;
    localparam logic [MEM_OP_W-1:0] MEM_OP_STB = 3'd4;
    localparam logic [MEM_OP_W-1:0] MEM_OP_STH = 3'd5;
    localparam logic [MEM_OP_W-1:0] MEM_OP_STW = 3'd6;
    typedef enum logic [1:0] {
        PIPE_ST_RUN        = 2'd0,
        PIPE_ST_LOAD_STALL = 2'd1,
        PIPE_ST_MEM_WAIT   = 2'd2
    } pipe_st_e;
    // Matching fields of an in-flight instruction; the MEM slot needs only these.
    typedef struct packed {
        logic                  valid;
        logic                  we_;
        logic [REG_ADDR_W-1:0] dst;
    } tag_t;
    typedef struct packed {
        tag_t tag;
        logic is_load;
    } slot_t;
    localparam int TAG_W  = $bits(tag_t);
    localparam int SLOT_W = $bits(slot_t);
    function automatic logic is_load_op(input logic [MEM_OP_W-1:0] op);
        return op inside {MEM_OP_LDB, MEM_OP_LDH, MEM_OP_LDW};
    endfunction
    // r0 is hardwired zero, so a write to it never produces a value worth forwarding.
    function automatic logic tag_hit(input tag_t t, input logic [REG_ADDR_W-1:0] a);
        return t.valid && !t.we_ && (t.dst != '0) && (t.dst == a);
    endfunction
endpackage

// File: rtl/pipe_ctrl_fwd_sel.sv
// pipe_ctrl_fwd_sel: per-operand forwarding select and load-use hazard flag.
module pipe_ctrl_fwd_sel import pipe_ctrl_pkg::*; #(
    parameter int FWD_W = FWD_CTRL_BUS
) (
    input  logic [REG_ADDR_W-1:0] src_addr,
    input  logic                  used,
    input  logic [SLOT_W-1:0]     ex_slot,
    input  logic [TAG_W-1:0]      mem_tag,
    output logic [FWD_W-1:0]      fwd,
    output logic                  load_haz
);
    slot_t ex;
    logic  ex_hit, mem_hit;
    assign ex       = ex_slot;
    assign ex_hit   = used && tag_hit(ex.tag, src_addr);
    assign mem_hit  = used && tag_hit(mem_tag, src_addr);
    assign fwd      = ex_hit ? FWD_W'(FWD_CTRL_EX) : mem_hit ? FWD_W'(FWD_CTRL_MEM) : FWD_W'(FWD_CTRL_NONE);
    assign load_haz = ex_hit && ex.is_load;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard controller driving forwarding selects, load-use stalls, memory-busy freezes and jump flushes.
// Build macro PIPE_CTRL_STATS_EN adds saturating stall_cnt/flush_cnt event counters.
module pipe_ctrl import pipe_ctrl_pkg::*; #(
    parameter int FWD_W = FWD_CTRL_BUS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_en,
    input  logic [REG_ADDR_W-1:0] ra_addr,
    input  logic [REG_ADDR_W-1:0] rb_addr,
    input  logic [1:0]            src_reg_used,
    input  logic [REG_ADDR_W-1:0] dst_addr,
    input  logic                  gpr_we_,
    input  logic [MEM_OP_W-1:0]   mem_op,
    input  logic                  jump_taken,
    input  logic                  mem_busy,
    output logic [FWD_W-1:0]      ra_fwd_ctrl,
    output logic [FWD_W-1:0]      rb_fwd_ctrl,
    output logic                  if_stall,
    output logic                  id_stall,
    output logic                  id_flush,
    output logic                  if_flush,
    output logic                  ex_stall,
    output logic                  mem_stall
`ifdef PIPE_CTRL_STATS_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           flush_cnt
`endif
);
    slot_t            ex_q, ex_d;
    tag_t             mem_q, mem_d;
    pipe_st_e         state_q, state_d;
    logic [FWD_W-1:0] ra_fwd, rb_fwd;
    logic             ra_haz, rb_haz;
    logic             if_stall_c, id_stall_c, id_flush_c, if_flush_c, frz_c;

    pipe_ctrl_fwd_sel #(.FWD_W(FWD_W)) u_fwd_ra (
        .src_addr (ra_addr),
        .used     (src_reg_used[SRC_USE_RA]),
        .ex_slot  (ex_q),
        .mem_tag  (mem_q),
        .fwd      (ra_fwd),
        .load_haz (ra_haz)
    );

    pipe_ctrl_fwd_sel #(.FWD_W(FWD_W)) u_fwd_rb (
        .src_addr (rb_addr),
        .used     (src_reg_used[SRC_USE_RB]),
        .ex_slot  (ex_q),
        .mem_tag  (mem_q),
        .fwd      (rb_fwd),
        .load_haz (rb_haz)
    );

    // Memory busy freezes everything, else a load-use inserts one bubble, else advance and flush on a taken jump.
    always_comb begin
        state_d    = PIPE_ST_RUN;
        ex_d       = ex_q;
        mem_d      = mem_q;
        if_stall_c = 1'b0;
        id_stall_c = 1'b0;
        id_flush_c = 1'b0;
        if_flush_c = 1'b0;
        frz_c      = 1'b0;
        if (mem_busy) begin
            state_d    = PIPE_ST_MEM_WAIT;
            if_stall_c = 1'b1;
            id_stall_c = 1'b1;
            frz_c      = 1'b1;
        end else if (ra_haz || rb_haz) begin
            state_d    = PIPE_ST_LOAD_STALL;
            if_stall_c = 1'b1;
            id_flush_c = 1'b1;
            ex_d       = '0;
            mem_d      = ex_q.tag;
        end else begin
            if_flush_c = jump_taken && if_en && (state_q != PIPE_ST_MEM_WAIT);
            ex_d       = '{tag: '{valid: if_en, we_: gpr_we_, dst: dst_addr}, is_load: is_load_op(mem_op)};
            mem_d      = ex_q.tag;
        end
    end

    assign ra_fwd_ctrl = reset ? ra_fwd : '0;
    assign rb_fwd_ctrl = reset ? rb_fwd : '0;
    assign if_stall    = reset && if_stall_c;
    assign id_stall    = reset && id_stall_c;
    assign id_flush    = reset && id_flush_c;
    assign if_flush    = reset && if_flush_c;
    assign ex_stall    = reset && frz_c;
    assign mem_stall   = reset && frz_c;

    // State and shadow slots; reset drops any stall in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= PIPE_ST_RUN;
            ex_q    <= '0;
            mem_q   <= '0;
        end else begin
            state_q <= state_d;
            ex_q    <= ex_d;
            mem_q   <= mem_d;
        end
    end

`ifdef PIPE_CTRL_STATS_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    // Saturating event counters for IF stalls and IF flushes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (if_stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (if_flush && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and random checks of pipe_ctrl against an instruction-history model.
module tb_pipe_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       if_en;
    logic [4:0] ra_addr, rb_addr, dst_addr;
    logic [1:0] src_reg_used;
    logic       gpr_we_;
    logic [2:0] mem_op;
    logic       jump_taken, mem_busy;
    logic [1:0] ra_fwd_ctrl, rb_fwd_ctrl;
    logic       if_stall, id_stall, id_flush, if_flush, ex_stall, mem_stall;
`ifdef PIPE_CTRL_STATS_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    pipe_ctrl #(.FWD_W(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .if_en        (if_en),
        .ra_addr      (ra_addr),
        .rb_addr      (rb_addr),
        .src_reg_used (src_reg_used),
        .dst_addr     (dst_addr),
        .gpr_we_      (gpr_we_),
        .mem_op       (mem_op),
        .jump_taken   (jump_taken),
        .mem_busy     (mem_busy),
        .ra_fwd_ctrl  (ra_fwd_ctrl),
        .rb_fwd_ctrl  (rb_fwd_ctrl),
        .if_stall     (if_stall),
        .id_stall     (id_stall),
        .id_flush     (id_flush),
        .if_flush     (if_flush),
        .ex_stall     (ex_stall),
        .mem_stall    (mem_stall)
`ifdef PIPE_CTRL_STATS_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    // An instruction that has left ID: does it write a nonzero register, which one, is it a load.
    typedef struct {
        bit w;
        int dst;
        bit ld;
    } ins_t;

    ins_t    hist[$];
    bit      was_wait;
    longint  m_stall, m_flush;
    int      n_chk = 0, n_err = 0;
    logic [1:0] g_ra, g_rb;
    logic [5:0] g_ctl;

    function automatic logic [5:0] ctl_now();
        return {if_stall, id_stall, id_flush, if_flush, ex_stall, mem_stall};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic mreset();
        ins_t b;
        b = '{w: 0, dst: 0, ld: 0};
        hist = {b, b};
        was_wait = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    function automatic int sel(input bit used, input int src);
        if (!used) return 0;
        if (hist[0].w && hist[0].dst == src) return 1;
        if (hist[1].w && hist[1].dst == src) return 2;
        return 0;
    endfunction

    // One clock cycle: drive decoder inputs, compare all outputs to the model, advance the model.
    task automatic cyc(input bit en, input int ra, input int rb, input bit [1:0] use_m, input int dst,
                       input bit we_n, input int op, input bit jmp, input bit busy);
        int   era, erb;
        bit   lu;
        logic [5:0] ectl;
        ins_t ni;
        if_en        = en;
        ra_addr      = 5'(ra);
        rb_addr      = 5'(rb);
        src_reg_used = use_m;
        dst_addr     = 5'(dst);
        gpr_we_      = we_n;
        mem_op       = 3'(op);
        jump_taken   = jmp;
        mem_busy     = busy;
        #2;
        era = sel(use_m[0], ra);
        erb = sel(use_m[1], rb);
        lu  = hist[0].ld && (era == 1 || erb == 1);
        ni  = '{w: en && !we_n && dst != 0, dst: dst, ld: op >= 1 && op <= 3};
        if (busy) begin
            ectl = 6'b110011;
        end else if (lu) begin
            ectl = 6'b101000;
            hist.push_front('{w: 0, dst: 0, ld: 0});
            void'(hist.pop_back());
        end else begin
            ectl = {3'b000, jmp && en && !was_wait, 2'b00};
            hist.push_front(ni);
            void'(hist.pop_back());
        end
        g_ra  = ra_fwd_ctrl;
        g_rb  = rb_fwd_ctrl;
        g_ctl = ctl_now();
        check("ra_fwd", 32'(g_ra), 32'(era));
        check("rb_fwd", 32'(g_rb), 32'(erb));
        check("ctl", 32'(g_ctl), 32'(ectl));
`ifdef PIPE_CTRL_STATS_EN
        check("stall_cnt", stall_cnt, 32'(m_stall));
        check("flush_cnt", flush_cnt, 32'(m_flush));
`endif
        m_stall += ectl[5];
        m_flush += ectl[2];
        was_wait = busy;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ra"}, 32'(ra_fwd_ctrl), 0);
        check({tag, "_rb"}, 32'(rb_fwd_ctrl), 0);
        check({tag, "_ctl"}, 32'(ctl_now()), 0);
    endtask

    initial begin
        // Reset held low with busy and a live-looking operand: all outputs forced to zero.
        reset = 1'b0;
        if_en = 1; ra_addr = 5'd3; rb_addr = 5'd3; src_reg_used = 2'b11; dst_addr = 5'd3;
        gpr_we_ = 0; mem_op = 3'd3; jump_taken = 1; mem_busy = 1;
        #3;
        check_zero("reset");
        mem_busy = 0;
        #1;
        check_zero("reset_nobusy");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        mreset();

        // Back-to-back ALU dependency: ADD r3 ; SUB r3,...
        cyc(1, 0, 0, 2'b00, 3, 0, 0, 0, 0);
        cyc(1, 3, 1, 2'b01, 6, 0, 0, 0, 0);
        check("b2b_ex", 32'(g_ra), 1);
        check("b2b_nostall", 32'(g_ctl), 0);

        // Distance-2 dependency, then EX-over-MEM priority.
        cyc(1, 0, 0, 2'b00, 5, 0, 0, 0, 0);
        cyc(1, 0, 0, 2'b00, 7, 0, 0, 0, 0);
        cyc(1, 0, 5, 2'b10, 8, 1, 0, 0, 0);
        check("dist2_mem", 32'(g_rb), 2);
        cyc(1, 0, 0, 2'b00, 5, 0, 0, 0, 0);
        cyc(1, 0, 0, 2'b00, 5, 0, 0, 0, 0);
        cyc(1, 0, 5, 2'b10, 8, 1, 0, 0, 0);
        check("prio_ex", 32'(g_rb), 1);

        // Load-use: LDW r4 ; ADD r4 -> one bubble, then MEM forward.
        cyc(1, 0, 0, 2'b00, 4, 0, 3, 0, 0);
        cyc(1, 4, 0, 2'b01, 9, 0, 0, 0, 0);
        check("lu_stall", 32'(g_ctl), 32'(6'b101000));
        cyc(1, 4, 0, 2'b01, 9, 0, 0, 0, 0);
        check("lu_fwd_mem", 32'(g_ra), 2);
        check("lu_resume", 32'(g_ctl), 0);

        // r0 never forwards.
        cyc(1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 2'b01, 10, 0, 0, 0, 0);
        check("r0_none", 32'(g_ra), 0);

        // Taken jump without hazard flushes for exactly one cycle.
        cyc(1, 1, 2, 2'b11, 0, 1, 0, 1, 0);
        check("jmp_flush", 32'(g_ctl), 32'(6'b000100));
        cyc(1, 0, 0, 2'b00, 0, 1, 0, 0, 0);
        check("jmp_once", 32'(g_ctl), 0);

        // Taken jump on a load-use operand: no flush in the stall cycle.
        cyc(1, 0, 0, 2'b00, 2, 0, 1, 0, 0);
        cyc(1, 2, 0, 2'b01, 0, 1, 0, 1, 0);
        check("jmp_lu_noflush", 32'(g_ctl), 32'(6'b101000));
        cyc(1, 2, 0, 2'b01, 0, 1, 0, 1, 0);
        check("jmp_lu_after", 32'(g_ctl), 32'(6'b000100));

        // Memory busy for 3 cycles: full freeze, slots held, then resume.
        cyc(1, 0, 0, 2'b00, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 2'b01, 11, 0, 0, 1, 1);
            check("frz_ctl", 32'(g_ctl), 32'(6'b110011));
            check("frz_hold", 32'(g_ra), 1);
        end
        cyc(1, 1, 0, 2'b01, 11, 0, 0, 1, 0);
        check("frz_end", 32'(g_ctl), 0);
        check("frz_end_fwd", 32'(g_ra), 1);

        // Reset in cycle 2 of a freeze: outputs drop at once, slots come back empty.
        cyc(1, 0, 0, 2'b00, 1, 0, 3, 0, 0);
        cyc(1, 1, 0, 2'b01, 12, 0, 0, 1, 1);
        if_en = 1; ra_addr = 5'd1; src_reg_used = 2'b01; mem_busy = 1; jump_taken = 1;
        #2;
        reset = 1'b0;
        #1;
        check_zero("rst_frz");
        @(posedge clk);
        #1;
        reset = 1'b1;
        mreset();
        cyc(1, 1, 1, 2'b11, 0, 1, 0, 0, 0);
        check("rst_slots_empty", 32'(g_ra), 0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3) == 0,
                $urandom_range(0, 6), $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
